// File: rtl/sirv_gnrl_vr_fifo_pkg.sv
// Shared helpers for the general valid/ready FIFO.
// Pointer width stays at least one bit so a DP=1 FIFO still has a legal pointer.
package sirv_gnrl_vr_fifo_pkg;

  function automatic int ptr_w(input int dp);
    return (dp > 1) ? $clog2(dp) : 1;
  endfunction

endpackage

// File: rtl/sirv_gnrl_dfflr.sv
// General DFF library cell with load enable.
// Asynchronous active-low reset clears the register to zero.
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  logic [DW-1:0] q;

  // Register loads dnxt only when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (lden) begin
      q <= dnxt;
    end
  end

  assign qout = q;

endmodule

// File: rtl/sirv_gnrl_fifo_ptr.sv
// Wrap-around FIFO pointer counting 0..DP-1.
// Safe for non-power-of-2 depths; for DP=1 it stays at 0.
module sirv_gnrl_fifo_ptr
  import sirv_gnrl_vr_fifo_pkg::*;
#(
  parameter int DP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [ptr_w(DP)-1:0]  ptr
);

  localparam int PW = ptr_w(DP);
  localparam logic [PW-1:0] LAST = PW'(DP - 1);

  logic [PW-1:0] nxt;

  assign nxt = (ptr == LAST) ? '0 : ptr + 1'b1;

  sirv_gnrl_dfflr #(.DW(PW)) u_ptr (
    .clk  (clk),
    .reset(reset),
    .lden (inc),
    .dnxt (nxt),
    .qout (ptr)
  );

endmodule

// File: rtl/sirv_gnrl_vr_fifo.sv
// Synchronous valid/ready FIFO built from general DFF cells.
// Define SIRV_GNRL_FIFO_BYPASS_EN for a zero-latency pass-through when empty.
module sirv_gnrl_vr_fifo
  import sirv_gnrl_vr_fifo_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 4,
  parameter int CW = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] count
);

  localparam int PW = ptr_w(DP);
  localparam logic [CW-1:0] FULL = CW'(DP);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [DW-1:0] mem [DP];
  logic [CW-1:0] cnt_nxt;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;

  assign empty = (count == '0);
  assign full  = (count == FULL);

  // Readiness depends on occupancy only, never on o_rdy.
  assign i_rdy = reset & ~full;

`ifdef SIRV_GNRL_FIFO_BYPASS_EN
  logic byp;

  assign byp   = reset & empty & i_vld;
  assign o_vld = ~empty | byp;
  assign o_dat = byp ? i_dat : mem[rptr];
  assign push  = i_vld & i_rdy & ~(byp & o_rdy);
  assign pop   = ~empty & o_rdy;
`else
  assign o_vld = ~empty;
  assign o_dat = mem[rptr];
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;
`endif

  assign cnt_nxt = push ? count + 1'b1 : count - 1'b1;

  sirv_gnrl_dfflr #(.DW(CW)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .lden (push ^ pop),
    .dnxt (cnt_nxt),
    .qout (count)
  );

  sirv_gnrl_fifo_ptr #(.DP(DP)) u_wptr (
    .clk  (clk),
    .reset(reset),
    .inc  (push),
    .ptr  (wptr)
  );

  sirv_gnrl_fifo_ptr #(.DP(DP)) u_rptr (
    .clk  (clk),
    .reset(reset),
    .inc  (pop),
    .ptr  (rptr)
  );

  for (genvar i = 0; i < DP; i++) begin : g_ent
    sirv_gnrl_dfflr #(.DW(DW)) u_ent (
      .clk  (clk),
      .reset(reset),
      .lden (push & (wptr == PW'(i))),
      .dnxt (i_dat),
      .qout (mem[i])
    );
  end

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!reset) !(push & ~pop & full)
  );

  a_no_udf: assert property (
    @(posedge clk) disable iff (!reset) !(pop & ~push & empty)
  );

endmodule

// File: tb/tb_sirv_gnrl_vr_fifo.sv
// Bench for sirv_gnrl_vr_fifo: DP=4 and DP=3 instances share stimulus.
// Queue models track both; directed steps add fixed expectations.
module tb_sirv_gnrl_vr_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_vld;
  logic       o_rdy;
  logic [7:0] i_dat;

  logic       a_i_rdy, a_o_vld;
  logic [7:0] a_o_dat;
  logic [2:0] a_count;
  logic       b_i_rdy, b_o_vld;
  logic [7:0] b_o_dat;
  logic [1:0] b_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit pa_push, pa_pop, pb_push, pb_pop;

  always #5 clk = ~clk;

  sirv_gnrl_vr_fifo #(.DW(8), .DP(4)) u_a (
    .clk(clk), .reset(reset),
    .i_vld(i_vld), .i_rdy(a_i_rdy), .i_dat(i_dat),
    .o_vld(a_o_vld), .o_rdy(o_rdy), .o_dat(a_o_dat),
    .count(a_count)
  );

  sirv_gnrl_vr_fifo #(.DW(8), .DP(3)) u_b (
    .clk(clk), .reset(reset),
    .i_vld(i_vld), .i_rdy(b_i_rdy), .i_dat(i_dat),
    .o_vld(b_o_vld), .o_rdy(o_rdy), .o_dat(b_o_dat),
    .count(b_count)
  );

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mchk(input string n, input int d, input logic [7:0] q[$],
                      input logic rdy, input logic vld,
                      input logic [7:0] dat, input logic [31:0] cnt,
                      output bit push, output bit pop);
    int sz;
    bit e_vld;
    logic [7:0] e_dat;
    sz = q.size();
    push = 0;
    pop = 0;
    if (!reset) begin
      cmp({n, "_rst_cnt"}, cnt, 0);
      cmp({n, "_rst_vld"}, 32'(vld), 0);
      cmp({n, "_rst_rdy"}, 32'(rdy), 0);
    end else begin
`ifdef SIRV_GNRL_FIFO_BYPASS_EN
      e_vld = (sz != 0) || i_vld;
      e_dat = (sz != 0) ? q[0] : i_dat;
      pop   = (sz != 0) && o_rdy;
      push  = i_vld && (sz != d) && !((sz == 0) && o_rdy);
`else
      e_vld = (sz != 0);
      e_dat = (sz != 0) ? q[0] : 8'h00;
      pop   = e_vld && o_rdy;
      push  = i_vld && (sz != d);
`endif
      cmp({n, "_cnt"}, cnt, 32'(sz));
      cmp({n, "_i_rdy"}, 32'(rdy), 32'(sz != d));
      cmp({n, "_o_vld"}, 32'(vld), 32'(e_vld));
      if (e_vld) cmp({n, "_o_dat"}, 32'(dat), 32'(e_dat));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    mchk("a", 4, qa, a_i_rdy, a_o_vld, a_o_dat, 32'(a_count),
         pa_push, pa_pop);
    mchk("b", 3, qb, b_i_rdy, b_o_vld, b_o_dat, 32'(b_count),
         pb_push, pb_pop);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    if (reset) begin
      if (pa_pop) void'(qa.pop_front());
      if (pa_push) qa.push_back(i_dat);
      if (pb_pop) void'(qb.pop_front());
      if (pb_push) qb.push_back(i_dat);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_vld = 1'b0;
    o_rdy = 1'b0;
    i_dat = 8'h00;
    #2 reset = 1'b0;
    #1;
    cmp("init_cnt", 32'(a_count), 0);
    cmp("init_vld", 32'(a_o_vld), 0);
    cmp("init_dat", 32'(a_o_dat), 0);
    cmp("init_rdy", 32'(a_i_rdy), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // fill / drain
    i_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_dat = 8'(17 * (k + 1));
      settle();
      clk_edge();
    end
    i_dat = 8'h55;
    settle();
    cmp("t1_full_cnt", 32'(a_count), 4);
    cmp("t1_full_rdy", 32'(a_i_rdy), 0);
    clk_edge();
    i_vld = 1'b0;
    settle();
    cmp("t1_refused_cnt", 32'(a_count), 4);
    cmp("t1_head", 32'(a_o_dat), 32'h11);
    clk_edge();
    o_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      cmp("t1_drain", 32'(a_o_dat), 32'(8'(17 * (k + 1))));
      clk_edge();
    end
    settle();
    cmp("t1_empty_cnt", 32'(a_count), 0);
    cmp("t1_empty_vld", 32'(a_o_vld), 0);
    clk_edge();

    // steady push/pop at count 2
    o_rdy = 1'b0;
    i_vld = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_dat = 8'(8'hA0 + k);
      settle();
      clk_edge();
    end
    o_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      i_dat = 8'(8'hA2 + k);
      settle();
      cmp("t2_cnt", 32'(a_count), 2);
      cmp("t2_dat", 32'(a_o_dat), 32'(8'(8'hA0 + k)));
      clk_edge();
    end
    i_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      cmp("t2_tail", 32'(a_o_dat), 32'(8'(8'hAA + k)));
      clk_edge();
    end
    settle();
    cmp("t2_empty", 32'(a_count), 0);
    clk_edge();

    // full with pop and push together
    o_rdy = 1'b0;
    i_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_dat = 8'(8'h61 + k);
      settle();
      clk_edge();
    end
    i_dat = 8'h66;
    o_rdy = 1'b1;
    settle();
    cmp("t3_full_cnt", 32'(a_count), 4);
    cmp("t3_full_rdy", 32'(a_i_rdy), 0);
    cmp("t3_head", 32'(a_o_dat), 32'h61);
    clk_edge();
    o_rdy = 1'b0;
    settle();
    cmp("t3_after_cnt", 32'(a_count), 3);
    cmp("t3_after_rdy", 32'(a_i_rdy), 1);
    clk_edge();
    i_vld = 1'b0;
    settle();
    cmp("t3_accept_cnt", 32'(a_count), 4);
    clk_edge();
    o_rdy = 1'b1;
    settle();
    cmp("t3_head2", 32'(a_o_dat), 32'h62);
    clk_edge();
    o_rdy = 1'b0;
    settle();
    cmp("t3_cnt3", 32'(a_count), 3);
    clk_edge();

    // reset pulse mid-operation
    reset = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    cmp("t4_rst_cnt", 32'(a_count), 0);
    cmp("t4_rst_vld", 32'(a_o_vld), 0);
    cmp("t4_rst_dat", 32'(a_o_dat), 0);
    cmp("t4_rst_rdy", 32'(a_i_rdy), 0);
    cmp("t4_rst_bcnt", 32'(b_count), 0);
    settle();
    clk_edge();
    reset = 1'b1;
    settle();
    cmp("t4_post_rdy", 32'(a_i_rdy), 1);
    cmp("t4_post_vld", 32'(a_o_vld), 0);
    clk_edge();
    i_vld = 1'b1;
    i_dat = 8'h77;
    settle();
    clk_edge();
    i_vld = 1'b0;
    o_rdy = 1'b1;
    settle();
    cmp("t4_new_dat", 32'(a_o_dat), 32'h77);
    cmp("t4_new_cnt", 32'(a_count), 1);
    clk_edge();
    settle();
    cmp("t4_drained", 32'(a_o_vld), 0);
    clk_edge();

    // random traffic against queue models
    for (int c = 0; c < 300; c++) begin
      i_vld = 1'($urandom_range(0, 1));
      if (c < 100) o_rdy = ($urandom_range(0, 3) == 0);
      else o_rdy = ($urandom_range(0, 3) != 0);
      i_dat = 8'($urandom);
      settle();
      clk_edge();
    end

    // empty-FIFO beat, with and without reader ready
    i_vld = 1'b0;
    o_rdy = 1'b1;
    repeat (6) begin
      settle();
      clk_edge();
    end
    i_vld = 1'b1;
    i_dat = 8'h5A;
    settle();
`ifdef SIRV_GNRL_FIFO_BYPASS_EN
    cmp("t6_byp_vld", 32'(a_o_vld), 1);
    cmp("t6_byp_dat", 32'(a_o_dat), 32'h5A);
    cmp("t6_byp_cnt", 32'(a_count), 0);
    clk_edge();
    i_vld = 1'b0;
    settle();
    cmp("t6_byp_after", 32'(a_count), 0);
    clk_edge();
`else
    cmp("t6_reg_vld", 32'(a_o_vld), 0);
    cmp("t6_reg_cnt", 32'(a_count), 0);
    clk_edge();
    i_vld = 1'b0;
    settle();
    cmp("t6_reg_vld1", 32'(a_o_vld), 1);
    cmp("t6_reg_dat1", 32'(a_o_dat), 32'h5A);
    clk_edge();
`endif
    i_vld = 1'b1;
    o_rdy = 1'b0;
    settle();
`ifdef SIRV_GNRL_FIFO_BYPASS_EN
    cmp("t6_hold_vld", 32'(a_o_vld), 1);
    cmp("t6_hold_dat", 32'(a_o_dat), 32'h5A);
`else
    cmp("t6_hold_vld", 32'(a_o_vld), 0);
`endif
    clk_edge();
    i_vld = 1'b0;
    settle();
    cmp("t6_store_cnt", 32'(a_count), 1);
    cmp("t6_store_dat", 32'(a_o_dat), 32'h5A);
    clk_edge();
    o_rdy = 1'b1;
    settle();
    clk_edge();
    settle();
    cmp("t6_final_cnt", 32'(a_count), 0);
    clk_edge();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
